// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions.
// Holds the frame arbiter state encoding, the default frame length limit
// and the width of the per-frame beat counter.
// No ports (package).
package eth_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam int MAX_BEATS_DEFAULT = 192;
  localparam int BEAT_CNT_W        = 10;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice.
// Both the forward path (data/valid) and the backward path (ready) are
// registered, so m_ready never reaches s_ready combinationally.
// Ports:
//   clock, resetn         - clock and asynchronous active-low reset
//   s_data/s_valid/s_ready - upstream side
//   m_data/m_valid/m_ready - downstream side
module axis_skid_buffer #(
  parameter int WIDTH = 74
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  // Upstream may send whenever the overflow entry is free.
  assign s_ready = ~skid_valid;

  // The output register takes new data when it is empty or being drained;
  // otherwise a beat that arrives anyway lands in the skid entry, which
  // moves up on the next downstream acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!skid_valid) begin
      if (!m_valid || m_ready) begin
        m_valid <= s_valid;
        m_data  <= s_data;
      end else if (s_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
    end else if (m_ready) begin
      m_data     <= skid_data;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the 10G MAC TX AXIS FIFO.
// A granted requester owns the output until its tlast beat is accepted.
// Frames longer than MAX_BEATS are cut: the limit beat leaves with
// tlast=1/tuser=1 and the rest of the input frame is swallowed.
// Ports:
//   clock, resetn                    - tx_clk and asynchronous active-low reset
//   s_axis_*                         - PORTS requesters, port i in slice i
//   m_axis_*                         - registered output toward the MAC FIFO
//   grant                            - index of the owning requester
//   busy                             - a frame is in progress (PASS or DROP)
//   trunc_pulse                      - one-cycle pulse per truncated frame
module eth_tx_frame_arbiter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int PORTS      = 2,
  parameter int MAX_BEATS  = MAX_BEATS_DEFAULT
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tuser,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic [1:0]                  grant,
  output logic                        busy,
  output logic                        trunc_pulse
);

  localparam int                    BEAT_W     = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam logic [BEAT_CNT_W-1:0] LIMIT_IDX  = BEAT_CNT_W'(MAX_BEATS - 1);

  logic [1:0]            state;
  logic [1:0]            last_granted;
  logic [1:0]            winner;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_user;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;

  logic                  skid_ready;
  logic                  pass_accept;
  logic                  truncate;
  logic [BEAT_W-1:0]     skid_in;
  logic [BEAT_W-1:0]     skid_out;

  // Round-robin pick: candidates are visited farthest-first so the one
  // nearest to last_granted+1 is written last and wins.
  always_comb begin
    winner = last_granted;
    for (int i = PORTS; i >= 1; i--) begin
      for (int j = 0; j < PORTS; j++) begin
        if (j == (int'(last_granted) + i) % PORTS && s_axis_tvalid[j]) begin
          winner = 2'(j);
        end
      end
    end
  end

  // Route the granted requester's beat to the shared datapath.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant == 2'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  // Only the owner sees ready; in DROP beats are discarded so no
  // back-pressure applies. skid_ready is a register output.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      s_axis_tready[i] = (grant == 2'(i)) &&
                         (((state == ST_PASS) && skid_ready) || (state == ST_DROP));
    end
  end

  assign pass_accept = (state == ST_PASS) && sel_valid && skid_ready;
  assign truncate    = pass_accept && !sel_last && (beat_cnt == LIMIT_IDX);
  assign skid_in     = {sel_data, sel_keep, sel_last | truncate, sel_user | truncate};
  assign busy        = (state != ST_IDLE);

  // Frame FSM. beat_cnt holds the number of beats already accepted in
  // the current frame, so the limit beat is seen when it equals MAX-1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      grant        <= 2'd0;
      last_granted <= 2'(PORTS - 1);
      beat_cnt     <= '0;
      trunc_pulse  <= 1'b0;
    end else begin
      trunc_pulse <= truncate;
      case (state)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            grant        <= winner;
            last_granted <= winner;
            beat_cnt     <= '0;
            state        <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (pass_accept) begin
            if (sel_last) begin
              state <= ST_IDLE;
            end else if (truncate) begin
              state <= ST_DROP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (sel_valid && sel_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_out_slice (
    .clock   (clock),
    .resetn  (resetn),
    .s_data  (skid_in),
    .s_valid ((state == ST_PASS) && sel_valid),
    .s_ready (skid_ready),
    .m_data  (skid_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter (2 ports, MAX_BEATS = 8).
// Accepted input beats are turned into expected output beats by a small
// truncation model and queued; the output monitor pops and compares.
module tb_eth_tx_frame_arbiter;

  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int NP   = 2;
  localparam int MAXB = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  logic             clock = 1'b0;
  logic             resetn;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP*KW-1:0] s_axis_tkeep;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tlast;
  logic [NP-1:0]    s_axis_tuser;
  logic [NP-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             m_axis_tready;
  logic [1:0]       grant;
  logic             busy;
  logic             trunc_pulse;

  logic [DW-1:0] drv_data  [NP];
  logic [KW-1:0] drv_keep  [NP];
  logic          drv_valid [NP];
  logic          drv_last  [NP];
  logic          drv_user  [NP];

  int    checks;
  int    errors;
  int    cyc = 0;
  int    acc_cnt [NP];
  int    mcnt    [NP];
  logic  mdrop   [NP];
  logic  trunc_due;
  logic  rand_ready;
  logic  out_sof;
  int    obs_trunc;
  int    obs_beats;
  int    obs_frames;
  int    first_out_cyc;
  int    last_out_cyc;
  int    out_ports [$];
  beat_t exp_q [$];
  beat_t mon_e;
  beat_t mon_got;

  eth_tx_frame_arbiter #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .PORTS      (NP),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .busy          (busy),
    .trunc_pulse   (trunc_pulse)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream ready: constant 1 unless the random phase is enabled.
  always @(posedge clock) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Pack per-port drivers onto the flat DUT buses.
  always_comb begin
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    for (int p = 0; p < NP; p++) begin
      s_axis_tdata[p*DW +: DW] = drv_data[p];
      s_axis_tkeep[p*KW +: KW] = drv_keep[p];
      s_axis_tvalid[p]         = drv_valid[p];
      s_axis_tlast[p]          = drv_last[p];
      s_axis_tuser[p]          = drv_user[p];
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one frame on port p; beat fields identify port, frame and beat.
  task automatic applyStimulus(input int p, input int len, input logic bad, input int fid);
    int guard;
    for (int b = 0; b < len; b++) begin
      drv_data[p]  = {8'(p), 16'(fid), 16'(b), 24'($urandom)};
      drv_keep[p]  = (b == len - 1) ? 8'h0F : 8'hFF;
      drv_last[p]  = (b == len - 1);
      drv_user[p]  = bad && (b == len - 1);
      drv_valid[p] = 1'b1;
      guard = 0;
      do begin
        @(negedge clock);
        guard++;
      end while (resetn && !s_axis_tready[p] && guard < 2000);
      if (!resetn) begin
        drv_valid[p] = 1'b0;
        drv_last[p]  = 1'b0;
        return;
      end
      if (!s_axis_tready[p]) begin
        checkOutput("tready_timeout", 128'(s_axis_tready[p]), 128'(1));
        drv_valid[p] = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    drv_valid[p] = 1'b0;
    drv_last[p]  = 1'b0;
    drv_user[p]  = 1'b0;
  endtask

  task automatic runPort(input int p, input int nframes, input int minl, input int maxl,
                         input logic randbad, input int fid_base);
    for (int f = 0; f < nframes; f++) begin
      applyStimulus(p, $urandom_range(minl, maxl), randbad && 1'($urandom_range(0, 1)),
                    fid_base + f);
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy || m_axis_tvalid) && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("drain_queue", 128'(exp_q.size()), 128'(0));
    checkOutput("drain_busy", 128'(busy), 128'(0));
  endtask

  // Model and monitor. Input acceptances feed the truncation model, the
  // output side pops the scoreboard; trunc_pulse must follow the limit
  // beat by exactly one cycle.
  always @(negedge clock) begin
    if (trunc_pulse) obs_trunc++;
    if (!resetn) begin
      exp_q.delete();
      for (int p = 0; p < NP; p++) begin
        mcnt[p]  = 0;
        mdrop[p] = 1'b0;
      end
      trunc_due = 1'b0;
      out_sof   = 1'b1;
    end else begin
      checkOutput("trunc_pulse", 128'(trunc_pulse), 128'(trunc_due));
      trunc_due = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (s_axis_tvalid[p] && s_axis_tready[p]) begin
          acc_cnt[p]++;
          if (mdrop[p]) begin
            if (s_axis_tlast[p]) begin
              mdrop[p] = 1'b0;
              mcnt[p]  = 0;
            end
          end else begin
            mcnt[p]++;
            mon_e.d = s_axis_tdata[p*DW +: DW];
            mon_e.k = s_axis_tkeep[p*KW +: KW];
            mon_e.l = s_axis_tlast[p];
            mon_e.u = s_axis_tuser[p];
            if (s_axis_tlast[p]) begin
              mcnt[p] = 0;
            end else if (mcnt[p] == MAXB) begin
              mon_e.l   = 1'b1;
              mon_e.u   = 1'b1;
              mdrop[p]  = 1'b1;
              trunc_due = 1'b1;
            end
            exp_q.push_back(mon_e);
          end
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        obs_beats++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (out_sof) out_ports.push_back(int'(m_axis_tdata[63:56]));
        out_sof = m_axis_tlast;
        if (m_axis_tlast) obs_frames++;
        mon_got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (exp_q.size() == 0) begin
          checkOutput("beat_expected", 128'(mon_got), 128'(0) - 128'(1));
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("beat", 128'(mon_got), 128'(mon_e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b0, f0, t0, a0, g;
    checks     = 0;
    errors     = 0;
    rand_ready = 1'b0;
    resetn     = 1'b0;
    obs_trunc  = 0;
    obs_beats  = 0;
    obs_frames = 0;
    first_out_cyc = -1;
    last_out_cyc  = -1;
    for (int p = 0; p < NP; p++) begin
      drv_data[p]  = '0;
      drv_keep[p]  = '0;
      drv_valid[p] = 1'b0;
      drv_last[p]  = 1'b0;
      drv_user[p]  = 1'b0;
      acc_cnt[p]   = 0;
    end

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    checkOutput("rst_s_tready", 128'(s_axis_tready), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_trunc", 128'(trunc_pulse), 128'(0));
    checkOutput("rst_grant", 128'(grant), 128'(0));
    @(posedge clock);
    #1 resetn = 1'b1;

    // Port1 alone, 5 beats: grant, latency, count.
    b0 = obs_beats;
    f0 = obs_frames;
    fork
      applyStimulus(1, 5, 1'b0, 100);
      begin
        g = 0;
        do begin
          @(negedge clock);
          g++;
        end while (!(s_axis_tvalid[1] && s_axis_tready[1]) && g < 100);
        checkOutput("a_grant", 128'(grant), 128'(1));
        checkOutput("a_busy", 128'(busy), 128'(1));
        checkOutput("a_mvalid_before", 128'(m_axis_tvalid), 128'(0));
        @(negedge clock);
        checkOutput("a_mvalid_latency", 128'(m_axis_tvalid), 128'(1));
      end
    join
    waitDrain();
    checkOutput("a_beats", 128'(obs_beats - b0), 128'(5));
    checkOutput("a_frames", 128'(obs_frames - f0), 128'(1));

    // Both ports, back-to-back 3-beat frames: strict alternation.
    out_ports.delete();
    first_out_cyc = -1;
    fork
      runPort(0, 4, 3, 3, 1'b0, 200);
      runPort(1, 4, 3, 3, 1'b0, 300);
    join
    waitDrain();
    checkOutput("b_frames", 128'(out_ports.size()), 128'(8));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("b_order%0d", i), 128'(out_ports[i]), 128'(i % 2));
    end
    checkOutput("b_span", 128'(last_out_cyc - first_out_cyc + 1 <= 31), 128'(1));

    // 12-beat frame cut at 8, then a normal frame.
    t0 = obs_trunc;
    b0 = obs_beats;
    f0 = obs_frames;
    applyStimulus(0, 12, 1'b0, 400);
    applyStimulus(0, 5, 1'b0, 401);
    waitDrain();
    checkOutput("c_trunc", 128'(obs_trunc - t0), 128'(1));
    checkOutput("c_beats", 128'(obs_beats - b0), 128'(13));
    checkOutput("c_frames", 128'(obs_frames - f0), 128'(2));

    // Exactly MAX_BEATS with tlast: intact, no truncation.
    t0 = obs_trunc;
    b0 = obs_beats;
    applyStimulus(0, 8, 1'b1, 500);
    waitDrain();
    checkOutput("d_trunc", 128'(obs_trunc - t0), 128'(0));
    checkOutput("d_beats", 128'(obs_beats - b0), 128'(8));
    checkOutput("d_grant_hold", 128'(grant), 128'(0));

    // Random back-pressure, 100 frames of 1..20 beats.
    rand_ready = 1'b1;
    f0 = obs_frames;
    fork
      runPort(0, 50, 1, 20, 1'b1, 1000);
      runPort(1, 50, 1, 20, 1'b1, 2000);
    join
    waitDrain();
    checkOutput("e_frames", 128'(obs_frames - f0), 128'(100));
    rand_ready = 1'b0;
    @(posedge clock);
    #1;

    // Reset while beat 3 of a 6-beat frame is presented.
    a0 = acc_cnt[0];
    fork
      applyStimulus(0, 6, 1'b0, 600);
      begin
        g = 0;
        while (acc_cnt[0] < a0 + 2 && g < 100) begin
          @(negedge clock);
          g++;
        end
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        checkOutput("f_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        checkOutput("f_s_tready", 128'(s_axis_tready), 128'(0));
        checkOutput("f_busy", 128'(busy), 128'(0));
        checkOutput("f_trunc", 128'(trunc_pulse), 128'(0));
        checkOutput("f_grant", 128'(grant), 128'(0));
      end
    join
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    out_ports.delete();
    fork
      applyStimulus(1, 4, 1'b0, 700);
      applyStimulus(0, 4, 1'b0, 701);
    join
    waitDrain();
    checkOutput("f_frames", 128'(out_ports.size()), 128'(2));
    checkOutput("f_first_port", 128'(out_ports[0]), 128'(0));
    checkOutput("f_second_port", 128'(out_ports[1]), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXIS data width in bits; legal value is 64 only.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter PORTS, default 2, number of requesters; legal range 2..4.
REQ-004 SHALL have parameter MAX_BEATS, default 192, maximum beats per frame before truncation; legal range 8..1023.
REQ-005 SHALL have port clock  input  1  sole clock, 156.25 MHz tx_clk domain of the 10G MAC.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports s_axis_tdata/tkeep  input  PORTS*DATA_WIDTH / PORTS*KEEP_WIDTH  requester data and byte enables, port i in slice i.
REQ-008 SHALL have ports s_axis_tvalid/tlast/tuser  input  PORTS  requester handshake, end-of-frame and bad-frame flags.
REQ-009 SHALL have port s_axis_tready  output  PORTS  per-requester ready.
REQ-010 SHALL have ports m_axis_tdata/tkeep/tvalid/tlast/tuser (output) and m_axis_tready (input), DATA_WIDTH/KEEP_WIDTH/1/1/1/1  toward the MAC FIFO TX AXIS.
REQ-011 SHALL have port grant  output  2  index of the port currently owning the output.
REQ-012 SHALL have ports busy  output  1  (frame in progress) and trunc_pulse  output  1  (one-cycle pulse per truncated frame).

Function
REQ-013 SHALL arbitrate at frame granularity: once granted, a port keeps the output until its tlast beat is accepted.
REQ-014 SHALL use round-robin priority: search starts at (last granted index + 1) mod PORTS; after reset the last granted index is PORTS-1, so port 0 wins first.
REQ-015 SHALL implement states IDLE, PASS, DROP; IDLE->PASS when any tvalid is high (grant latched same cycle); PASS->IDLE on accepted tlast; PASS->DROP on truncation; DROP->IDLE on accepted input tlast.
REQ-016 SHALL assert s_axis_tready only for the granted port in PASS (when the output register can accept) and in DROP (unconditionally); all other tready are 0, and in IDLE all are 0.
REQ-017 SHALL register the output through a 2-entry skid buffer: latency 1 cycle input-accept to m_axis_tvalid; full throughput (1 beat/cycle) when m_axis_tready stays high; no combinational path m_axis_tready -> s_axis_tready.
REQ-018 SHALL pass tdata, tkeep, tlast, tuser unmodified in PASS except on the truncation beat.
REQ-019 SHALL count accepted beats of the current frame in a 10-bit counter cleared on entry to PASS; when the beat numbered MAX_BEATS is accepted without tlast, SHALL emit it with tlast=1, tuser=1, pulse trunc_pulse, and enter DROP.
REQ-020 SHALL, in DROP, accept and discard input beats of the granted port until its tlast, emitting nothing.
REQ-021 SHALL handle a frame whose tlast coincides with beat MAX_BEATS as normal (no truncation, no DROP).
REQ-022 SHALL allow a new grant in the cycle after the tlast acceptance (one idle input cycle between frames; output may remain back-to-back via skid buffer).
REQ-023 SHALL drive busy=1 in PASS and DROP; grant holds its value when IDLE.
REQ-024 SHALL never drop or duplicate beats when m_axis_tready toggles arbitrarily.

Reset
REQ-025 SHALL on resetn=0 asynchronously clear: state=IDLE, beat counter=0, skid buffer empty, m_axis_tvalid=0, all s_axis_tready=0, busy=0, trunc_pulse=0, grant=0, last-granted=PORTS-1.
REQ-026 SHALL, on reset mid-frame, discard any partial frame; no tlast is generated for it.
REQ-027 SHALL require resetn deassertion synchronous to clock (synchronised upstream).

Structure
REQ-028 SHALL place state encoding (IDLE/PASS/DROP) and the default MAX_BEATS constant in shared package eth_pkg.
REQ-029 SHALL use one sub-module, axis_skid_buffer (2-entry registered slice), for the output stage.

Verification
REQ-030 Port0 and port1 each send 3-beat frames continuously, m_axis_tready=1 -> output alternates 0,1,0,1; grant follows; no gaps between output frames beyond one cycle.
REQ-031 Port1 alone valid after reset, 5-beat frame -> grant=1, first m_axis_tvalid one cycle after first s_axis_tready, 5 beats, tlast on beat 5.
REQ-032 MAX_BEATS=8, port0 sends 12-beat frame -> 8 output beats, beat 8 tlast=1 tuser=1, trunc_pulse once, 4 beats discarded, next frame normal.
REQ-033 MAX_BEATS=8, 8-beat frame with tlast on beat 8 -> passed intact, tuser as input, no trunc_pulse.
REQ-034 Random m_axis_tready (50%) with 100 frames of random length 1..20 from 2 ports -> scoreboard matches every beat in order, no loss or duplication.
REQ-035 resetn pulsed low during beat 3 of a 6-beat frame -> all outputs at reset values same cycle; after release, next frame from port0 granted first and output intact.
